// File: rtl/async_transmitter_fifo.sv
// rtl/async_transmitter_fifo.sv - 8N1 UART transmitter with a small byte FIFO and fractional baud generator
module async_transmitter_fifo #(
  parameter int ClkFrequency          = 2000000,
  parameter int Baud                  = 115200,
  parameter int BaudGeneratorAccWidth = 16,
  parameter int FifoDepthLog2         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD_ready,
  output logic       TxD,
  output logic       TxD_busy,
  output logic       TxD_done
);

  localparam int AccW  = BaudGeneratorAccWidth;
  localparam int PtrW  = FifoDepthLog2;
  localparam int CntW  = FifoDepthLog2 + 1;
  localparam int Depth = 1 << FifoDepthLog2;

  // Rounded fractional increment; one carry out of the low AccW bits is one bit period.
  localparam logic [63:0] IncWide =
    ((64'(Baud) << (AccW - 4)) + (64'(ClkFrequency) >> 5)) / (64'(ClkFrequency) >> 4);
  localparam logic [AccW:0] Inc = IncWide[AccW:0];

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    B0    = 4'd2,
    B1    = 4'd3,
    B2    = 4'd4,
    B3    = 4'd5,
    B4    = 4'd6,
    B5    = 4'd7,
    B6    = 4'd8,
    B7    = 4'd9,
    STOP  = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [AccW:0]   acc_q, acc_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic [7:0]      shift_q, shift_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      mem_q [Depth];
  logic [7:0]      mem_d [Depth];

  logic            wr_en;
  logic            pop;
  logic            baud_tick;
  logic            fifo_nonempty;
  logic [7:0]      fifo_head;

  assign baud_tick     = acc_q[AccW];
  assign fifo_nonempty = (count_q != '0);
  assign fifo_head     = mem_q[rd_ptr_q];
  assign TxD_ready     = (count_q != CntW'(Depth));
  assign wr_en         = TxD_start && TxD_ready;
  assign TxD           = txd_q;
  assign TxD_busy      = (state_q != IDLE) || fifo_nonempty;
  assign TxD_done      = done_q;

  // Bit sequencer: one state per bit period, advancing on baud ticks; chains frames with no idle gap.
  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START, B0, B1, B2, B3, B4, B5, B6: begin
        if (baud_tick) begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = state_t'(state_q + 4'd1);
        end
      end
      B7: begin
        if (baud_tick) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping and baud accumulator; accumulator restarts from zero at every frame launched from IDLE.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = TxD_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (state_d == IDLE) begin
      acc_d = '0;
    end else begin
      acc_d = {1'b0, acc_q[AccW-1:0]} + Inc;
    end
  end

  // Control registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
      shift_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
      shift_q  <= shift_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful where the count says so, so no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_async_transmitter_fifo.sv
// tb/tb_async_transmitter_fifo.sv - self-checking bench for async_transmitter_fifo
module tb_async_transmitter_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       ready, txd, busy, done;
  logic       start_d;
  logic [7:0] data_d;
  logic       ready_d, txd_d, busy_d, done_d;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [9:0] exp_frame;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  logic [9:0] c_cap;
  int         c_wait;
  bit         c_uns, c_dsn, c_busylow, c_to;

  logic [9:0] caps[6];
  int         waits[6];
  bit         unss[6], dsns[6], bls[6], tos[6];
  logic [5:0] rdy;
  int         lat, n, slen, total;
  bit         bad;

  always #5 clk = ~clk;

  async_transmitter_fifo #(
    .ClkFrequency(1600000), .Baud(100000), .BaudGeneratorAccWidth(16), .FifoDepthLog2(2)
  ) dut (
    .clk(clk), .rst(rst), .TxD_start(start), .TxD_data(data),
    .TxD_ready(ready), .TxD(txd), .TxD_busy(busy), .TxD_done(done)
  );

  async_transmitter_fifo dut_def (
    .clk(clk), .rst(rst), .TxD_start(start_d), .TxD_data(data_d),
    .TxD_ready(ready_d), .TxD(txd_d), .TxD_busy(busy_d), .TxD_done(done_d)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Queue one byte from IDLE and stop on the first negedge showing the start bit.
  task automatic start_and_align(input logic [7:0] d, output int l);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    l     = 0;
    do begin
      @(posedge clk);
      l++;
      @(negedge clk);
      start = 1'b0;
    end while (txd !== 1'b0 && l < 40);
  endtask

  // Sample 16 negedges per bit; the first sample of each bit is its level.
  task automatic capture(input bit aligned);
    logic lvl;
    c_cap = '0; c_wait = 0; c_uns = 0; c_dsn = 0; c_busylow = 0; c_to = 0;
    lvl = 1'b1;
    if (!aligned) begin
      @(negedge clk);
      while (txd !== 1'b0 && c_wait < 2000) begin
        c_wait++;
        @(negedge clk);
      end
      if (txd !== 1'b0) begin
        c_to = 1;
        return;
      end
    end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 16; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        if (c == 0) begin
          lvl      = txd;
          c_cap[i] = txd;
        end else if (txd !== lvl) begin
          c_uns = 1;
        end
        if (done === 1'b1) c_dsn = 1;
        if (busy !== 1'b1) c_busylow = 1;
      end
    end
  endtask

  task automatic check_captured(input string tag, input logic [9:0] exp);
    check({tag, "_timeout"}, c_to, 0);
    check({tag, "_frame"}, c_cap, exp);
    check({tag, "_bit_len"}, c_uns, 0);
    check({tag, "_early_done"}, c_dsn, 0);
    check({tag, "_busy_drop"}, c_busylow, 0);
  endtask

  task automatic check_done_pulse(input string tag);
    @(negedge clk);
    check({tag, "_done_hi"}, done, 1);
    check({tag, "_stop_hi"}, txd, 1);
    @(negedge clk);
    check({tag, "_done_lo"}, done, 0);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    bit b;
    b = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (txd !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) b = 1;
    end
    check({tag, "_idle"}, b, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int l;
    start_and_align(v.data, l);
    check({v.name, "_latency"}, l, v.exp_lat);
    capture(1);
    check_captured(v.name, v.exp_frame);
    check_done_pulse(v.name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench stalled");
  end

  initial begin
    vecs[0] = '{name: "v55", data: 8'h55, exp_frame: 10'h2AA, exp_lat: 2};
    vecs[1] = '{name: "vC3", data: 8'hC3, exp_frame: 10'h386, exp_lat: 2};
    vecs[2] = '{name: "v01", data: 8'h01, exp_frame: 10'h202, exp_lat: 2};
    vecs[3] = '{name: "vFE", data: 8'hFE, exp_frame: 10'h3FC, exp_lat: 2};
    vecs[4] = '{name: "v80", data: 8'h80, exp_frame: 10'h300, exp_lat: 2};

    rst = 1'b1; start = 1'b0; data = '0; start_d = 1'b0; data_d = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    check("rst_txd_def", txd_d, 1);
    check("rst_ready_def", ready_d, 1);
    rst = 1'b0;
    idle_watch("post_rst", 5);

    // Single frames, exact 16-clock bit periods.
    for (int k = 0; k < 4; k++) begin
      run_frame(vecs[k]);
      idle_watch({vecs[k].name, "_after"}, 5);
    end

    // Two bytes back to back.
    fork
      begin
        @(negedge clk); start = 1'b1; data = 8'hA3;
        @(negedge clk); data = 8'h0F;
        @(negedge clk); start = 1'b0;
      end
      begin
        for (int k = 0; k < 2; k++) begin
          capture(0);
          caps[k] = c_cap; waits[k] = c_wait; unss[k] = c_uns;
          dsns[k] = c_dsn; bls[k] = c_busylow; tos[k] = c_to;
        end
      end
    join
    check("b2b_f1", caps[0], 10'h346);
    check("b2b_f2", caps[1], 10'h21E);
    check("b2b_gap", waits[1], 0);
    check("b2b_to", {tos[0], tos[1]}, 0);
    check("b2b_len", {unss[0], unss[1]}, 0);
    check("b2b_done_between", {dsns[0], dsns[1]}, 0);
    check_done_pulse("b2b");
    idle_watch("b2b_after", 20);

    // Six writes into a 4-deep FIFO; the sixth finds it full.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          start = 1'b1;
          data  = 8'(k + 1);
          rdy[k] = ready;
        end
        @(negedge clk); start = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          capture(0);
          caps[k] = c_cap; waits[k] = c_wait; unss[k] = c_uns;
          dsns[k] = c_dsn; bls[k] = c_busylow; tos[k] = c_to;
        end
      end
    join
    check("full_ready_seq", rdy, 6'b011111);
    check("full_f1", caps[0], 10'h202);
    check("full_f2", caps[1], 10'h204);
    check("full_f3", caps[2], 10'h206);
    check("full_f4", caps[3], 10'h208);
    check("full_f5", caps[4], 10'h20A);
    check("full_gaps", waits[1] + waits[2] + waits[3] + waits[4], 0);
    check("full_busy", {bls[0], bls[1], bls[2], bls[3], bls[4]}, 0);
    check("full_len", {unss[0], unss[1], unss[2], unss[3], unss[4]}, 0);
    check("full_to", {tos[0], tos[1], tos[2], tos[3], tos[4]}, 0);
    check("full_done_between", {dsns[0], dsns[1], dsns[2], dsns[3], dsns[4]}, 0);
    check_done_pulse("full");
    idle_watch("full_no_sixth", 200);

    // Reset in the middle of B3 of a 0x00 frame with a second byte queued.
    @(negedge clk); start = 1'b1; data = 8'h00;
    @(negedge clk); data = 8'h11;
    @(negedge clk); start = 1'b0;
    check("abort_fall", txd, 0);
    repeat (72) @(negedge clk);
    check("abort_b3_level", txd, 0);
    check("abort_b3_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_txd", txd, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_watch("abort_discard", 400);
    run_frame(vecs[4]);

    // Default parameters: fractional bit period.
    @(negedge clk);
    check("def_idle_before", txd_d, 1);
    start_d = 1'b1; data_d = 8'hFF;
    @(negedge clk);
    start_d = 1'b0;
    n = 0;
    while (txd_d !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("def_fall", txd_d, 0);
    slen = 0;
    while (txd_d === 1'b0 && slen < 100) begin
      slen++;
      @(negedge clk);
    end
    total = slen;
    bad = 0;
    while (done_d !== 1'b1 && total < 400) begin
      if (txd_d !== 1'b1) bad = 1;
      total++;
      @(negedge clk);
    end
    check_range("def_start_len", slen, 17, 18);
    check_range("def_frame_len", total, 173, 174);
    check("def_data_high", bad, 0);
    check("def_done", done_d, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd_d !== 1'b1 || done_d !== 1'b0 || busy_d !== 1'b0) bad = 1;
    end
    check("def_idle_after", bad, 0);

    // Write landing on the stop-bit tick with an empty FIFO.
    start_and_align(8'h55, lat);
    check("stopwr_latency", lat, 2);
    capture(1);
    check_captured("stopwr_f1", 10'h2AA);
    start = 1'b1; data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    check("stopwr_done", done, 1);
    check("stopwr_idle_bit", txd, 1);
    check("stopwr_busy", busy, 1);
    capture(0);
    check("stopwr_restart", c_wait, 0);
    check_captured("stopwr_f2", 10'h278);
    check_done_pulse("stopwr");
    idle_watch("stopwr_after", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
